// File: rtl/kws_pkg.sv
// +--------------------------------------------------------------------------+
// | kws_pkg : shared op codes and scheduler state encodings                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package kws_pkg;

  localparam logic [1:0] SA_OP_MATMUL = 2'b00;
  localparam logic [1:0] SA_OP_CONV   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

  // Index width that stays legal (>=1 bit) for a count of one.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kws_systolic_sched_if.sv
// +--------------------------------------------------------------------------+
// | kws_systolic_sched_if : requester / array bundle of the scheduler        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface kws_systolic_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [LEN_W*NUM_REQ-1:0] req_len;
  logic                     sa_ready;
  logic                     abort;
  logic [NUM_REQ-1:0]       gnt;
  logic                     systolic_en;
  logic [1:0]               systolic_op;
  logic [LEN_W-1:0]         beat_idx;
  logic [NUM_REQ-1:0]       job_done;
  logic                     job_abort;
  logic                     busy;

  modport master (
    output req, req_op, req_len, sa_ready, abort,
    input  gnt, systolic_en, systolic_op, beat_idx, job_done, job_abort, busy
  );

  modport slave (
    input  req, req_op, req_len, sa_ready, abort,
    output gnt, systolic_en, systolic_op, beat_idx, job_done, job_abort, busy
  );
endinterface

`default_nettype wire

// File: rtl/kws_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | kws_rr_arbiter : combinational round-robin pick from a rotating pointer  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module kws_rr_arbiter
  import kws_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int pos;

  // First set bit at or above rr_ptr, wrapping past N-1 back to 0.
  always_comb begin
    valid = 1'b0;
    gnt   = '0;
    idx   = '0;
    pos   = 0;
    for (int off = 0; off < N; off++) begin
      pos = int'(rr_ptr) + off;
      if (pos >= N) pos = pos - N;
      if (!valid && req[pos[IW-1:0]]) begin
        valid               = 1'b1;
        gnt[pos[IW-1:0]]    = 1'b1;
        idx                 = pos[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/kws_systolic_sched.sv
// +--------------------------------------------------------------------------+
// | kws_systolic_sched : round-robin time-sharing of the systolic array      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module kws_systolic_sched
  import kws_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LEN_W        = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  kws_systolic_sched_if.slave  bus
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int DW = idx_w(DRAIN_CYCLES);

  sched_state_e       state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]         op_q, op_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               aborted_q, aborted_d;

  logic               arb_valid;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic [1:0]         sel_op;
  logic [LEN_W-1:0]   sel_len;

  kws_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (arb_valid),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  always_comb begin
    sel_op  = '0;
    sel_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_op  = bus.req_op[2*i +: 2];
        sel_len = bus.req_len[LEN_W*i +: LEN_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    gnt_d       = gnt_q;
    aborted_d   = aborted_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          idx_d      = arb_idx;
          op_d       = sel_op;
          len_d      = sel_len;
          gnt_d      = arb_gnt;
          beat_cnt_d = '0;
          aborted_d  = 1'b0;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        beat_cnt_d = '0;
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort outranks a coinciding final-beat transfer.
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (bus.sa_ready) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == len_q - 1'b1) begin
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        rr_ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        gnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
      op_q        <= SA_OP_MATMUL;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      gnt_q       <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      gnt_q       <= gnt_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.systolic_en = (state_q == ST_RUN);
  assign bus.systolic_op = (state_q == ST_IDLE) ? 2'b00 : op_q;
  assign bus.beat_idx    = (state_q == ST_RUN) ? beat_cnt_q : '0;
  assign bus.job_done    = (state_q == ST_DONE) ? gnt_q : '0;
  assign bus.job_abort   = (state_q == ST_DONE) && aborted_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_kws_systolic_sched.sv
// +--------------------------------------------------------------------------+
// | tb_kws_systolic_sched : directed + randomized checks of the scheduler    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_kws_systolic_sched;
  import kws_pkg::*;

  localparam int N  = 4;
  localparam int LW = 8;
  localparam int D  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  kws_systolic_sched_if #(.NUM_REQ(N), .LEN_W(LW)) sif ();

  kws_systolic_sched #(.NUM_REQ(N), .LEN_W(LW), .DRAIN_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  int checks  = 0;
  int errors  = 0;
  int rr_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int rr);
    for (int off = 0; off < N; off++) begin
      int j;
      j = (rr + off) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  // One complete job from the IDLE cycle through the following IDLE cycle.
  task automatic do_job(input logic [N-1:0] mask, input logic [2*N-1:0] ops,
                        input logic [LW*N-1:0] lens, input bit rnd,
                        input logic [31:0] rpat, input int abort_at,
                        input bit scramble, output int win);
    int len, cnt, stalls, lat, k;
    logic [1:0] op;
    bit ab, r, a, fin;
    win = pick(mask, rr_model);
    op  = ops[2*win +: 2];
    len = int'(lens[LW*win +: LW]);
    sif.req = mask; sif.req_op = ops; sif.req_len = lens;
    sif.sa_ready = 1'b0; sif.abort = 1'b0;
    @(posedge clk); #1;
    lat = 0;
    chk("setup_gnt",  32'(sif.gnt), 32'(1 << win));
    chk("setup_en",   32'(sif.systolic_en), 32'd0);
    chk("setup_op",   32'(sif.systolic_op), 32'(op));
    chk("setup_busy", 32'(sif.busy), 32'd1);
    cnt = 0; stalls = 0; ab = 1'b0; k = 0; fin = (len == 0);
    while (!fin) begin
      @(posedge clk); #1;
      lat++;
      chk("run_en",   32'(sif.systolic_en), 32'd1);
      chk("run_idx",  32'(sif.beat_idx), 32'(cnt));
      chk("run_op",   32'(sif.systolic_op), 32'(op));
      chk("run_done", 32'(sif.job_done), 32'd0);
      r = rnd ? ($urandom_range(3) != 0) : rpat[k];
      a = (abort_at >= 0) && (cnt == abort_at);
      k++;
      sif.sa_ready = r; sif.abort = a;
      if (scramble) begin
        sif.req = N'($urandom); sif.req_op = (2*N)'($urandom); sif.req_len = (LW*N)'($urandom);
      end
      if (a) begin
        ab = 1'b1; fin = 1'b1;
      end else if (r) begin
        cnt++;
        if (cnt == len) fin = 1'b1;
      end else begin
        stalls++;
      end
      if (!fin && k > 600) begin
        checks++; errors++;
        $error("FAIL run_bound observed=%0d expected<=600 beats", k);
        fin = 1'b1;
      end
    end
    if (!ab && len > 0) begin
      for (int i = 0; i < D; i++) begin
        @(posedge clk); #1;
        sif.sa_ready = 1'b0; sif.abort = 1'b0;
        lat++;
        chk("drain_en",   32'(sif.systolic_en), 32'd0);
        chk("drain_done", 32'(sif.job_done), 32'd0);
        chk("drain_op",   32'(sif.systolic_op), 32'(op));
      end
    end
    @(posedge clk); #1;
    sif.sa_ready = 1'b0; sif.abort = 1'b0;
    lat++;
    chk("done_pulse", 32'(sif.job_done), 32'(1 << win));
    chk("done_abort", 32'(sif.job_abort), 32'(ab));
    chk("done_gnt",   32'(sif.gnt), 32'(1 << win));
    chk("done_en",    32'(sif.systolic_en), 32'd0);
    if (!ab) chk("latency", 32'(lat), 32'((len == 0) ? 1 : 1 + len + D + stalls));
    sif.req = '0;
    rr_model = (win + 1) % N;
    @(posedge clk); #1;
    chk("idle_busy", 32'(sif.busy), 32'd0);
    chk("idle_gnt",  32'(sif.gnt), 32'd0);
    chk("idle_done", 32'(sif.job_done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int w, w0, l0, ab_at;
    logic [N-1:0]    m;
    logic [2*N-1:0]  o;
    logic [LW*N-1:0] l;

    rst_n = 1'b0;
    sif.req = '0; sif.req_op = '0; sif.req_len = '0; sif.sa_ready = 1'b0; sif.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",  32'(sif.gnt), 32'd0);
    chk("rst_en",   32'(sif.systolic_en), 32'd0);
    chk("rst_op",   32'(sif.systolic_op), 32'd0);
    chk("rst_idx",  32'(sif.beat_idx), 32'd0);
    chk("rst_done", 32'(sif.job_done), 32'd0);
    chk("rst_abt",  32'(sif.job_abort), 32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Everyone requesting: strict rotation starting from requester 0.
    for (int k = 0; k < 5; k++) begin
      do_job(4'b1111, 8'b11_10_01_00, {4{8'd2}}, 1'b0, '1, -1, 1'b0, w);
      chk("order", 32'(w), 32'(k % N));
    end

    // Single conv job of four beats on requester 1.
    o = '0; o[3:2] = SA_OP_CONV;
    do_job(4'b0010, o, 32'h0000_0400, 1'b0, '1, -1, 1'b0, w);
    chk("t1_win", 32'(w), 32'd1);

    // Back-pressure pattern 1,0,0,1,1,1.
    do_job(4'b0001, 8'h00, 32'h0000_0004, 1'b0, 32'b111001, -1, 1'b0, w);
    chk("t3_win", 32'(w), 32'd0);

    // Abort after beat 2, then the pointer moves past the aborted owner.
    do_job(4'b1111, 8'h00, {4{8'd8}}, 1'b0, '1, 2, 1'b0, w);
    chk("t4_win", 32'(w), 32'd1);
    do_job(4'b1111, 8'h00, {4{8'd1}}, 1'b0, '1, -1, 1'b0, w);
    chk("t4_next", 32'(w), 32'd2);

    // Zero-length job: SETUP straight to DONE.
    do_job(4'b1000, 8'hC0, 32'h0005_0505, 1'b0, '1, -1, 1'b0, w);
    chk("t5_win", 32'(w), 32'd3);

    // Randomized jobs with inputs scrambled while a job is in flight.
    for (int n = 0; n < 24; n++) begin
      m = N'($urandom_range(1, 15));
      o = (2*N)'($urandom);
      for (int i = 0; i < N; i++) l[LW*i +: LW] = LW'($urandom_range(0, 12));
      w0 = pick(m, rr_model);
      l0 = int'(l[LW*w0 +: LW]);
      ab_at = (l0 > 0 && $urandom_range(3) == 0) ? int'($urandom_range(0, l0 - 1)) : -1;
      do_job(m, o, l, 1'b1, '0, ab_at, 1'b1, w);
    end

    // Asynchronous reset in the middle of RUN.
    sif.req = 4'b0100; sif.req_op = 8'h55; sif.req_len = {4{8'd8}};
    @(posedge clk); #1;
    sif.sa_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t6_pre_en", 32'(sif.systolic_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_gnt",  32'(sif.gnt), 32'd0);
    chk("t6_en",   32'(sif.systolic_en), 32'd0);
    chk("t6_busy", 32'(sif.busy), 32'd0);
    chk("t6_op",   32'(sif.systolic_op), 32'd0);
    sif.req = 4'b0101; sif.sa_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr_model = 0;
    do_job(4'b0101, 8'h00, {4{8'd2}}, 1'b0, '1, -1, 1'b0, w);
    chk("t6_win", 32'(w), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/kws_systolic_sched.md
Name: kws_systolic_sched

Overview:
Time-multiplexes the single shared systolic array between NUM_REQ compute requesters (LINEAR, CNN and future layers).
- Arbitrates round-robin.
- Latches the winner's operation and beat count.
- Streams systolic_en beats under array back-pressure, flushes the array pipeline, then returns a one-cycle completion pulse to the winner.
- Sits between the layer-control FSM enables and the systolic array's systolic_en/systolic_op inputs.

Parameters:
NUM_REQ, 4, number of requesters (≥2).
LEN_W, 8, width of per-job beat count.
DRAIN_CYCLES, 3, array pipeline flush cycles after the last beat (≥1).

Ports:
clk  input  1  clock.
rst_n  input  1  reset; one clock, asynchronous assert, active-low.
req  input  NUM_REQ  per-requester job request; level; held until own job_done.
req_op  input  2*NUM_REQ  op per requester, slice i = [2i+1:2i]; 00 matmul, 01 conv, 1x reserved (passed through).
req_len  input  LEN_W*NUM_REQ  beats per job, slice i.
sa_ready  input  1  array accepts the current beat.
abort  input  1  synchronous kill of the active job.
gnt  output  NUM_REQ  one-hot owner, SETUP through DONE.
systolic_en  output  1  beat valid to the array.
systolic_op  output  2  latched op of the active job.
beat_idx  output  LEN_W  index of the current beat.
job_done  output  NUM_REQ  one-cycle one-hot completion pulse.
job_abort  output  1  high with job_done when the job ended by abort.
busy  output  1  state != IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; round-robin pointer = 0, so req[0] has top priority first.
- All outputs decode only from flops; no input-to-output combinational path.
- IDLE: if any req is set, pick the first set bit scanning from rr_ptr upward with wrap. Latch index, op and len, then go to SETUP. gnt is registered from the accept edge.
- SETUP (1 cycle): systolic_op valid, systolic_en=0, beat_cnt=0. Go to DONE if latched len==0, else RUN.
- RUN: systolic_en=1 and beat_idx=beat_cnt.
  - A beat transfers on a cycle with sa_ready=1; beat_cnt increments.
  - With sa_ready=0, beat_idx/op hold.
  - Transfer of beat len-1 → DRAIN, drain_cnt=0.
- DRAIN: systolic_en=0, op held; count DRAIN_CYCLES cycles → DONE.
- DONE (1 cycle):
  - job_done[idx]=1 and gnt still asserted.
  - rr_ptr = (idx+1) mod NUM_REQ.
  - Next state IDLE.
  - A new job cannot be accepted in the DONE cycle; the minimum gap is one IDLE cycle.
- Unaborted latency from SETUP entry: job_done at cycle 1+len+DRAIN_CYCLES+stall cycles.
- abort:
  - In SETUP, RUN or DRAIN: next state DONE, with job_abort=1 alongside job_done. Partial beats are not replayed.
  - In IDLE or DONE: ignored.
- Requester deasserting req mid-job: ignored; the job runs to completion.
- req_op/req_len changes after acceptance: ignored.
- Async reset mid-job: outputs 0 immediately; job lost; rr_ptr back to 0.
- beat_cnt is LEN_W bits; len up to 2^LEN_W-1 with no wrap.
- Simultaneous abort and final beat in RUN: abort wins (DONE, job_abort=1).

Decomposition:
- kws_pkg holds:
  - SA_OP_MATMUL=2'b00 and SA_OP_CONV=2'b01.
  - Scheduler state encodings IDLE, SETUP, RUN, DRAIN and DONE.
- Sub-module kws_rr_arbiter: combinational pick of req and rr_ptr, producing a one-hot grant and index. It is reusable for the SRAM port sharing.

Test Plan:
1. req=0010, op1=01, len1=4, sa_ready=1, abort=0 → gnt=0010, systolic_op=01, systolic_en high exactly 4 cycles with beat_idx 0..3. 3 drain cycles follow, then job_done=0010 for one cycle, 8 cycles after SETUP entry.
2. req=1111 held, all len=2, each requester drops req after its job_done and re-raises → grant order 0,1,2,3,0 with one IDLE cycle between jobs.
3. len=4, sa_ready pattern 1,0,0,1,1,1 → systolic_en high 6 cycles; beat_idx 0,1,1,1,2,3; job_done after 3 drain cycles.
4. len=8, abort pulsed after beat 2 transfers → next cycle is DONE with job_done and job_abort high; next grant goes to idx+1.
5. len=0 on req[3] → SETUP then DONE with no systolic_en; job_done=1000 at cycle 2 after acceptance.
6. rst_n low during RUN → all outputs 0 asynchronously; after release, a pending req[2] with req[0] also set grants req[0] first.
